display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Time-multiplexed 7-segment driver for the N-bit value chosen by the display-source mux; sits directly downstream of that mux and drives the board's common-anode digit enables and segment lines. Captures the selected value on a load strobe, scans one hex digit at a time at a programmable refresh rate, and optionally blanks leading zeros. All outputs are registered, so pad timing is glitch-free.

## Interface
- N, default 16: width of displayed value; must be a multiple of 4; DIGITS = N/4.
- REFRESH_DIV, default 100000: clk cycles each digit stays lit; must be ≥ 2.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- value  input  N  display value from the source mux.
- load  input  1  capture `value` into the hold register on this edge.
- en  input  1  display enable; low turns all digits off.
- blank_lz  input  1  leading-zero blanking enable.
- an  output  DIGITS  digit enables, active-low, one-hot-low when lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; always 1 (off).
- digit_tick  output  1  one-cycle pulse when scan advances to the next digit.

## Operation
- Hold register `val_q` (N bits): reset 0; loads `value` on any edge with load=1; otherwise holds. The scan always shows `val_q`, never `value` directly.
- Prescaler `cnt`: counts 0..REFRESH_DIV-1, wraps to 0; runs regardless of en.
- Digit index `idx`: increments when cnt = REFRESH_DIV-1; wraps DIGITS-1 → 0. digit_tick = 1 on that same cycle, registered.
- Nibble for digit i = val_q[4i+3:4i]; digit 0 is least significant, rightmost.
- Hex decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex values of seg).
- Leading-zero blanking: digit i (i>0) is blank when blank_lz=1 and every nibble i..DIGITS-1 is zero. Digit 0 is never blanked. A blank digit drives seg=7F; its anode is still asserted, so the scan duty cycle is unchanged.
- en=0: an all ones, seg=7F; cnt and idx keep running.
- Lit digit: an = ~(1 << idx), seg = decode or blank.

## Timing
- Reset values: an all ones, seg=7F, dp=1, digit_tick=0, idx=0, cnt=0, val_q=0.
- an and seg are registered from the idx, val_q, en and blank_lz values of the previous cycle, giving 1-cycle latency.
- A load at edge t shows the new nibble on seg at edge t+1 for the currently lit digit.
- load on the same cycle as an idx advance: the new idx and the new val_q both appear on edge t+1. No mixed frame.
- First lit output after reset release: edge 1 shows an = ...1110, seg = decode(0) = 40.
- Full scan period = DIGITS × REFRESH_DIV cycles.
- rst_n low mid-scan: all state returns to reset values on that edge, including val_q.

## Structure
- Package `display_pkg`:
  - 16-entry `HEX7SEG` constant array.
  - `SEG_OFF` = 7'h7F.
  - `seg_t` typedef, logic [6:0].
- Sub-module `hex_to_7seg`: purely combinational, nibble in, seg_t out, using the package table.
- Top-level contents: prescaler, idx, val_q, blank logic, output registers.

## Test plan
All scenarios use N=16, REFRESH_DIV=4.
1. Reset, then release with en=1 and blank_lz=0 → an cycles E,D,B,7, each for 4 cycles; seg=40 throughout; digit_tick pulses every 4 cycles.
2. load with value=16'h1A8F → over one scan, seg = 0E on digit 0, 00 on digit 1, 08 on digit 2, 79 on digit 3. Changing `value` with load=0 has no effect.
3. blank_lz=1, val_q=16'h0005 → digits 3..1 show seg=7F with anodes still pulsed; digit 0 shows 12. With val_q=0, only digit 0 shows 40.
4. en dropped mid-scan → an=F from the next edge. en re-raised → resumes at the current idx; no scan reset.
5. load coincident with the cnt=3 wrap → the next lit digit shows the new nibble immediately, and the old value never appears on that digit.
6. rst_n low for 1 cycle mid-scan → the next edge gives an=F, seg=7F, val_q=0, and the scan restarts at digit 0 with the 4-cycle dwell.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// display_pkg: shared types and constants for the 7-segment scan driver.
//   seg_t    - 7-bit segment vector {g,f,e,d,c,b,a}, active-low
//   SEG_OFF  - all segments dark
//   HEX7SEG  - hex digit 0..F to active-low segment pattern
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX7SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/display_scan_driver_if.sv
// display_scan_driver_if: groups the display-source side and the pad side of
// the scan driver.
//   value      N       value from the display-source mux
//   load       1       capture value into the hold register
//   en         1       display enable
//   blank_lz   1       leading-zero blanking enable
//   an         N/4     digit enables, active-low
//   seg        7       segments {g,f,e,d,c,b,a}, active-low
//   dp         1       decimal point, active-low (always off)
//   digit_tick 1       pulse when the scan advances
// master: the block feeding the driver; slave: the driver itself.
interface display_scan_driver_if
    import display_pkg::*;
#(
    parameter int N = 16
) ();

    localparam int DIGITS = N / 4;

    logic [N-1:0]      value;
    logic              load;
    logic              en;
    logic              blank_lz;
    logic [DIGITS-1:0] an;
    seg_t              seg;
    logic              dp;
    logic              digit_tick;

    modport master (
        output value, load, en, blank_lz,
        input  an, seg, dp, digit_tick
    );

    modport slave (
        input  value, load, en, blank_lz,
        output an, seg, dp, digit_tick
    );

endinterface

// File: rtl/display_scan_driver_hex_to_7seg.sv
// hex_to_7seg: combinational hex nibble to active-low 7-segment decoder.
//   nib  in   4  hex digit
//   seg  out  7  segment pattern {g,f,e,d,c,b,a}, active-low
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);

    assign seg = HEX7SEG[nib];

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: time-multiplexed common-anode 7-segment driver.
// Captures the source value on load, lights one hex digit at a time for
// REFRESH_DIV clocks each, optionally blanks leading zeros. All pad outputs
// are registered.
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   synchronous active-low reset
//   bus    slave modport of display_scan_driver_if (value/load/en/blank_lz in,
//                   an/seg/dp/digit_tick out)
module display_scan_driver
    import display_pkg::*;
#(
    parameter int N           = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_driver_if.slave  bus
);

    localparam int DIGITS = N / 4;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [N-1:0]      val_q;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              wrap;

    logic [DIGITS-1:0] onehot_p0;
    logic [DIGITS-1:0] lz_p0;
    logic [3:0]        nib_p0;
    logic              blank_p0;
    seg_t              dec_p0;

    logic [DIGITS-1:0] an_p1;
    seg_t              seg_p1;
    logic              dp_p1;
    logic              tick_p1;

    assign wrap = (cnt == CNT_W'(REFRESH_DIV - 1));

    // Stage p0: select the lit digit's nibble and decide blanking from the
    // current scan state and hold register.
    always_comb begin
        logic run_zero;
        onehot_p0 = '0;
        lz_p0     = '0;
        nib_p0    = 4'h0;
        blank_p0  = 1'b0;
        run_zero  = 1'b1;
        // lz_p0[i] is set when nibble i and every nibble above it are zero.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero & (val_q[4*i +: 4] == 4'h0);
            lz_p0[i] = run_zero;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                onehot_p0[i] = 1'b1;
                nib_p0       = val_q[4*i +: 4];
                // Digit 0 always shows, so a zero value still reads "0".
                blank_p0     = bus.blank_lz && (i != 0) && lz_p0[i];
            end
        end
    end

    hex_to_7seg u_dec (
        .nib (nib_p0),
        .seg (dec_p0)
    );

    // Stage p1: registered pad outputs plus the scan/hold state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q   <= '0;
            cnt     <= '0;
            idx     <= '0;
            an_p1   <= '1;
            seg_p1  <= SEG_OFF;
            dp_p1   <= 1'b1;
            tick_p1 <= 1'b0;
        end else begin
            if (bus.load) begin
                val_q <= bus.value;
            end
            // Prescaler and digit index keep running while the display is
            // disabled so re-enabling picks up mid-scan.
            if (wrap) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            tick_p1 <= wrap;
            dp_p1   <= 1'b1;
            if (!bus.en) begin
                an_p1  <= '1;
                seg_p1 <= SEG_OFF;
            end else begin
                // A blank digit keeps its anode so brightness is uniform.
                an_p1  <= ~onehot_p0;
                seg_p1 <= blank_p0 ? SEG_OFF : dec_p0;
            end
        end
    end

    assign bus.an         = an_p1;
    assign bus.seg        = seg_p1;
    assign bus.dp         = dp_p1;
    assign bus.digit_tick = tick_p1;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: directed and randomized checks of display_scan_driver
// (N=16, REFRESH_DIV=4) against a cycle-count based reference model.
module tb_display_scan_driver;

    localparam int R = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    display_scan_driver_if #(.N(16)) bus ();

    display_scan_driver #(.N(16), .REFRESH_DIV(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] hex [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Model state: edges since the last reset edge, and the held value.
    int          m_e   = 0;
    logic [15:0] m_val = '0;

    logic [6:0] seen_seg [D];
    logic [3:0] seen_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        for (int d = 0; d < D; d++) seen_seg[d] = 7'h7F;
        seen_hit = 4'h0;
    endtask

    task automatic step(input logic [15:0] v, input logic ld, input logic en_i,
                        input logic bl, input logic rn);
        int          ip;
        logic [15:0] up;
        logic [3:0]  xan;
        logic [6:0]  xseg;
        logic        xtick;
        bus.value    = v;
        bus.load     = ld;
        bus.en       = en_i;
        bus.blank_lz = bl;
        rst_n        = rn;
        if (!rn) begin
            xan = 4'hF; xseg = 7'h7F; xtick = 1'b0;
        end else begin
            ip    = (m_e / R) % D;
            up    = m_val >> (4 * ip);
            xan   = en_i ? ~(4'b0001 << ip) : 4'hF;
            if (!en_i)                      xseg = 7'h7F;
            else if (bl && ip > 0 && up == 0) xseg = 7'h7F;
            else                            xseg = hex[up[3:0]];
            xtick = ((m_e + 1) % R) == 0;
        end
        @(posedge clk);
        #1;
        if (!rn) begin
            m_e = 0; m_val = '0;
        end else begin
            m_e++;
            if (ld) m_val = v;
        end
        chk("an", 32'(bus.an), 32'(xan));
        chk("seg", 32'(bus.seg), 32'(xseg));
        chk("dp", 32'(bus.dp), 32'h1);
        chk("digit_tick", 32'(bus.digit_tick), 32'(xtick));
        if (rn && en_i) begin
            for (int d = 0; d < D; d++) begin
                if (bus.an == ~(4'b0001 << d)) begin
                    seen_seg[d] = bus.seg;
                    seen_hit[d] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int          e_cnt;
        int          nd;
        logic [15:0] nv;
        bus.value = '0; bus.load = 1'b0; bus.en = 1'b0; bus.blank_lz = 1'b0;
        clear_seen();

        // Reset state.
        step(16'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_seg", 32'(bus.seg), 32'h7F);

        // Scan of zero: E,D,B,7 for 4 cycles each, seg 40.
        step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("first_an", 32'(bus.an), 32'hE);
        chk("first_seg", 32'(bus.seg), 32'h40);
        for (int i = 0; i < 19; i++) step(16'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);

        // Load 1A8F; value changes without load ignored.
        step(16'h1A8F, 1'b1, 1'b1, 1'b0, 1'b1);
        clear_seen();
        for (int i = 0; i < 16; i++) step(16'($urandom), 1'b0, 1'b1, 1'b0, 1'b1);
        chk("scan_hit", 32'(seen_hit), 32'hF);
        chk("d0_1A8F", 32'(seen_seg[0]), 32'h0E);
        chk("d1_1A8F", 32'(seen_seg[1]), 32'h00);
        chk("d2_1A8F", 32'(seen_seg[2]), 32'h08);
        chk("d3_1A8F", 32'(seen_seg[3]), 32'h79);

        // Leading-zero blanking.
        step(16'h0005, 1'b1, 1'b1, 1'b1, 1'b1);
        clear_seen();
        for (int i = 0; i < 16; i++) step(16'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("lz5_hit", 32'(seen_hit), 32'hF);
        chk("lz5_d3", 32'(seen_seg[3]), 32'h7F);
        chk("lz5_d1", 32'(seen_seg[1]), 32'h7F);
        chk("lz5_d0", 32'(seen_seg[0]), 32'h12);
        step(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
        clear_seen();
        for (int i = 0; i < 16; i++) step(16'($urandom), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("lz0_d2", 32'(seen_seg[2]), 32'h7F);
        chk("lz0_d0", 32'(seen_seg[0]), 32'h40);

        // Enable dropped mid-scan and re-raised.
        step(16'hC0DE, 1'b1, 1'b1, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("en_off_an", 32'(bus.an), 32'hF);
        for (int i = 0; i < 6; i++) step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);

        // Load coincident with the prescaler wrap.
        for (int k = 0; k < 3; k++) begin
            e_cnt = 0;
            while ((m_e % R) != R - 1 && e_cnt < 8) begin
                step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
                e_cnt++;
            end
            nv = 16'($urandom) | 16'h1111;
            step(nv, 1'b1, 1'b1, 1'b0, 1'b1);
            nd = (m_e / R) % D;
            step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("wrap_load_seg", 32'(bus.seg), 32'(hex[4'((nv >> (4 * nd)) & 16'hF)]));
        end

        // One-cycle reset mid-scan, then 4-cycle dwell on digit 0.
        step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("midrst_an", 32'(bus.an), 32'hF);
        chk("midrst_seg", 32'(bus.seg), 32'h7F);
        e_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
            if (bus.an == 4'hE) e_cnt++;
        end
        chk("midrst_dwell", 32'(e_cnt), 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(16'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom),
                 ($urandom_range(0, 59) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
